// File: rtl/mean_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mean_sched_pkg
//  Description : Shared constants and helpers for the 16-channel
//                time-multiplexed running-mean scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package mean_sched_pkg;

  localparam int NCH = 16;  // number of acquisition channels
  localparam int DW  = 16;  // sample / result width
  localparam int CHW = 4;   // channel index width

  // Accumulator width that holds 2^shift full-scale samples without overflow
  function automatic int acc_width(input int shift);
    return DW + shift;
  endfunction

  // Extract the signed sample of one channel from the flat data bus
  function automatic logic signed [DW-1:0] ch_slice(input logic [NCH*DW-1:0] data,
                                                    input logic [CHW-1:0]    ch);
    return data[int'(ch)*DW +: DW];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational N-way round-robin arbiter. The search starts
//                one past the previous winner; the pointer register is kept
//                by the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N = 16
) (
  input  logic [N-1:0]         req,
  input  logic                 enable,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  // Scan from the farthest offset down to the nearest so the closest
  // requester after last_grant is the one left standing.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (enable) begin
      for (int i = N; i >= 1; i--) begin
        if (req[(int'(last_grant) + i) % N]) begin
          grant_valid = 1'b1;
          grant_idx   = IW'((int'(last_grant) + i) % N);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mean_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mean_scheduler
//  Description : Shares one running-mean datapath across 16 channels. Samples
//                are captured into hold registers, granted round-robin into
//                per-channel accumulators, and every 2^SHIFT samples of a
//                channel a channel-tagged mean is presented on a
//                valid/ready output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module mean_scheduler
  import mean_sched_pkg::*;
#(
  parameter int SHIFT = 3
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NCH-1:0]      CH_VALID,
  input  logic [NCH*DW-1:0]   CH_DATA,
  input  logic                OUT_READY,
  input  logic                CLR_OVR,
  output logic                OUT_VALID,
  output logic [CHW-1:0]      OUT_CH,
  output logic [DW-1:0]       OUT_DATA,
  output logic [NCH-1:0]      OVERRUN
);

  localparam int AW     = acc_width(SHIFT);
  localparam int AMOUNT = 1 << SHIFT;
  // SHIFT=0 needs no counter, but keep one bit so the array stays legal
  localparam int CW     = (SHIFT > 0) ? SHIFT : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(AMOUNT - 1);

  // Capture stage
  logic signed [DW-1:0] hold_q [NCH];
  logic signed [DW-1:0] hold_d [NCH];
  logic [NCH-1:0]       pending_q, pending_d;
  logic [NCH-1:0]       overrun_q, overrun_d;

  // Accumulate stage
  logic signed [AW-1:0] acc_q [NCH];
  logic signed [AW-1:0] acc_d [NCH];
  logic [CW-1:0]        cnt_q [NCH];
  logic [CW-1:0]        cnt_d [NCH];
  logic [CHW-1:0]       last_grant_q, last_grant_d;

  // Output register
  logic                 out_valid_q, out_valid_d;
  logic [CHW-1:0]       out_ch_q, out_ch_d;
  logic signed [DW-1:0] out_data_q, out_data_d;

  // Arbitration
  logic                 slot_free;
  logic                 grant_valid;
  logic [CHW-1:0]       grant_idx;
  logic signed [AW-1:0] sum;

  // Grants only when the output register is empty or emptying this edge
  assign slot_free = !out_valid_q || OUT_READY;

  rr_arbiter #(
    .N (NCH)
  ) u_arb (
    .req         (pending_q),
    .enable      (slot_free),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Capture new samples, retire granted ones and flag samples lost to overwrite
  always_comb begin
    hold_d    = hold_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (CLR_OVR) begin
      overrun_d = '0;
    end
    if (grant_valid) begin
      pending_d[grant_idx] = 1'b0;
    end
    for (int n = 0; n < NCH; n++) begin
      if (CH_VALID[n]) begin
        // An unconsumed sample being overwritten is a loss; applied after the
        // clear so a same-cycle set wins.
        if (pending_q[n] && !(grant_valid && (grant_idx == CHW'(n)))) begin
          overrun_d[n] = 1'b1;
        end
        hold_d[n]    = ch_slice(CH_DATA, CHW'(n));
        pending_d[n] = 1'b1;
      end
    end
  end

  // Accumulate the granted sample, or close the average and load the output
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_ch_d     = out_ch_q;
    out_data_d   = out_data_q;
    sum          = acc_q[grant_idx] + AW'(hold_q[grant_idx]);

    if (out_valid_q && OUT_READY) begin
      out_valid_d = 1'b0;
    end

    if (grant_valid) begin
      last_grant_d = grant_idx;
      if (cnt_q[grant_idx] != CNT_LAST) begin
        acc_d[grant_idx] = sum;
        cnt_d[grant_idx] = cnt_q[grant_idx] + CW'(1);
      end else begin
        out_valid_d      = 1'b1;
        out_ch_d         = grant_idx;
        // Arithmetic shift floors toward minus infinity
        out_data_d       = DW'(sum >>> SHIFT);
        acc_d[grant_idx] = '0;
        cnt_d[grant_idx] = '0;
      end
    end
  end

  // State registers; reset discards any partial averages
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int n = 0; n < NCH; n++) begin
        hold_q[n] <= '0;
        acc_q[n]  <= '0;
        cnt_q[n]  <= '0;
      end
      pending_q    <= '0;
      overrun_q    <= '0;
      last_grant_q <= CHW'(NCH - 1);
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_data_q   <= '0;
    end else begin
      hold_q       <= hold_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      out_data_q   <= out_data_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_CH    = out_ch_q;
  assign OUT_DATA  = out_data_q;
  assign OVERRUN   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_mean_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mean_scheduler
//  Description : Self-checking bench. Four schedulers (SHIFT = 0..3) share
//                one stimulus; a behavioural model predicts every output each
//                cycle, and directed scenarios pin key results to literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mean_scheduler;

  localparam int ND = 4;

  logic         clk;
  logic         rst;
  logic [15:0]  valid;
  logic [255:0] data;
  logic         ready;
  logic         clr;

  logic         o_valid [ND];
  logic [3:0]   o_ch    [ND];
  logic [15:0]  o_data  [ND];
  logic [15:0]  o_ovr   [ND];

  for (genvar k = 0; k < ND; k++) begin : g_dut
    mean_scheduler #(
      .SHIFT (k)
    ) u_dut (
      .CLK       (clk),
      .RESET     (rst),
      .CH_VALID  (valid),
      .CH_DATA   (data),
      .OUT_READY (ready),
      .CLR_OVR   (clr),
      .OUT_VALID (o_valid[k]),
      .OUT_CH    (o_ch[k]),
      .OUT_DATA  (o_data[k]),
      .OVERRUN   (o_ovr[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_total = 0;
  int n_pass  = 0;
  int cycle   = 0;
  bit armed   = 1'b0;

  typedef struct {
    int ch;
    int data;
    int cyc;
  } rec_t;
  rec_t xlog [ND][$];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  bit          mpend  [ND][16];
  int          mhold  [ND][16];
  int          macc   [ND][16];
  int          mcnt   [ND][16];
  int          mlast  [ND];
  logic [15:0] mov    [ND];
  bit          mvalid [ND];
  int          mch    [ND];
  int          mdata  [ND];

  function automatic int floor_div(input int num, input int den);
    int q;
    q = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_step(input int d);
    int amt, g, c, tot;
    amt = 1 << d;
    if (rst) begin
      for (int n = 0; n < 16; n++) begin
        mpend[d][n] = 0; mhold[d][n] = 0; macc[d][n] = 0; mcnt[d][n] = 0;
      end
      mlast[d] = 15; mov[d] = '0; mvalid[d] = 0; mch[d] = 0; mdata[d] = 0;
    end else begin
      g = -1;
      if (!mvalid[d] || ready) begin
        for (int i = 1; i <= 16; i++) begin
          c = (mlast[d] + i) % 16;
          if (g < 0 && mpend[d][c]) g = c;
        end
      end
      if (mvalid[d] && ready) mvalid[d] = 0;
      if (g >= 0) begin
        tot = macc[d][g] + mhold[d][g];
        mcnt[d][g] = mcnt[d][g] + 1;
        mpend[d][g] = 0;
        mlast[d] = g;
        if (mcnt[d][g] == amt) begin
          mvalid[d] = 1; mch[d] = g; mdata[d] = floor_div(tot, amt);
          macc[d][g] = 0; mcnt[d][g] = 0;
        end else begin
          macc[d][g] = tot;
        end
      end
      if (clr) mov[d] = '0;
      for (int n = 0; n < 16; n++) begin
        if (valid[n]) begin
          if (mpend[d][n]) mov[d][n] = 1'b1;  // still unconsumed after grant
          mhold[d][n] = int'($signed(data[16*n +: 16]));
          mpend[d][n] = 1;
        end
      end
    end
  endtask

  // Advance the model and log DUT transfers (pre-edge values)
  always @(posedge clk) begin
    cycle++;
    for (int d = 0; d < ND; d++) begin
      if (o_valid[d] === 1'b1 && ready) begin
        xlog[d].push_back('{int'(o_ch[d]), int'($signed(o_data[d])), cycle});
      end
      model_step(d);
    end
  end

  // Compare every DUT against the model on every falling edge
  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < ND; d++) begin
        logic [15:0] ed;
        ed = mdata[d][15:0];
        chk($sformatf("dut%0d OUT_VALID", d), int'(o_valid[d]), int'(mvalid[d]));
        chk($sformatf("dut%0d OUT_CH", d), int'(o_ch[d]), mch[d]);
        chk($sformatf("dut%0d OUT_DATA", d), int'(o_data[d]), int'(ed));
        chk($sformatf("dut%0d OVERRUN", d), int'(o_ovr[d]), int'(mov[d]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic strobe(input int ch, input int val);
    data[16*ch +: 16] = 16'(val);
    valid[ch] = 1'b1;
    cyc();
    valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int d = 0; d < ND; d++) xlog[d].delete();
  endtask

  // ---------------- directed + random scenarios ----------------
  initial begin
    int smp [16];
    int smp2 [16];
    rst = 1'b1; valid = '0; data = '0; ready = 1'b1; clr = 1'b0;
    cyc();
    armed = 1'b1;
    cyc();
    rst = 1'b0;

    // Reset state of every instance
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("reset dut%0d valid", d), int'(o_valid[d]), 0);
      chk($sformatf("reset dut%0d ovr", d), int'(o_ovr[d]), 0);
    end

    // Single channel, SHIFT=2
    strobe(3, 100); idle(19);
    strobe(3, 200); idle(19);
    strobe(3, -50); idle(19);
    strobe(3, 7);
    cyc();
    chk("s2 valid two edges after strobe", int'(o_valid[2]), 1);
    chk("s2 ch", int'(o_ch[2]), 3);
    chk("s2 mean 257>>>2", int'($signed(o_data[2])), 64);
    cyc();
    chk("s2 valid one cycle only", int'(o_valid[2]), 0);
    idle(5);
    chk("s2 output count", xlog[2].size(), 1);

    // Negative floor, SHIFT=1
    do_reset();
    strobe(0, -3); idle(19);
    strobe(0, -2); idle(5);
    chk("s1 output count", xlog[1].size(), 1);
    if (xlog[1].size() > 0) chk("s1 floor -5>>>1", xlog[1][0].data, -3);

    // All channels in one cycle, SHIFT=0, twice
    do_reset();
    for (int n = 0; n < 16; n++) begin
      smp[n]  = int'($urandom_range(0, 65535)) - 32768;
      smp2[n] = int'($urandom_range(0, 65535)) - 32768;
      data[16*n +: 16] = 16'(smp[n]);
    end
    valid = '1; cyc(); valid = '0;
    idle(15);
    for (int n = 0; n < 16; n++) data[16*n +: 16] = 16'(smp2[n]);
    valid = '1; cyc(); valid = '0;
    idle(30);
    chk("burst output count", xlog[0].size(), 32);
    if (xlog[0].size() == 32) begin
      for (int i = 0; i < 32; i++) begin
        chk($sformatf("burst ch order %0d", i), xlog[0][i].ch, i % 16);
        chk($sformatf("burst data %0d", i), xlog[0][i].data, (i < 16) ? smp[i] : smp2[i-16]);
      end
      chk("burst back-to-back span", xlog[0][31].cyc - xlog[0][0].cyc, 31);
    end
    chk("burst overrun", int'(o_ovr[0]), 0);

    // Backpressure on ch5
    do_reset();
    ready = 1'b0;
    strobe(5, 1234); idle(7);
    for (int k = 0; k < 4; k++) begin
      strobe(5, int'($urandom_range(0, 65535)) - 32768); idle(7);
    end
    chk("bp valid held", int'(o_valid[0]), 1);
    chk("bp data frozen", int'($signed(o_data[0])), 1234);
    chk("bp ch frozen", int'(o_ch[0]), 5);
    chk("bp overrun set", int'(o_ovr[0][5]), 1);
    ready = 1'b1;
    idle(20);
    chk("bp overrun sticky", int'(o_ovr[0][5]), 1);
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("bp overrun cleared", int'(o_ovr[0]), 0);

    // Same-cycle consume and arrive on ch7
    do_reset();
    data[16*7 +: 16] = 16'(10); valid[7] = 1'b1; cyc();
    data[16*7 +: 16] = 16'(21); cyc();
    valid = '0;
    idle(10);
    chk("cc overrun", int'(o_ovr[0][7]), 0);
    chk("cc s0 count", xlog[0].size(), 2);
    if (xlog[0].size() == 2) begin
      chk("cc s0 first", xlog[0][0].data, 10);
      chk("cc s0 second", xlog[0][1].data, 21);
    end
    chk("cc s1 count", xlog[1].size(), 1);
    if (xlog[1].size() > 0) chk("cc s1 mean", xlog[1][0].data, 15);

    // Reset mid-average, SHIFT=3
    do_reset();
    for (int k = 0; k < 5; k++) begin
      strobe(2, 1000); idle(19);
    end
    do_reset();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("midrst dut%0d valid", d), int'(o_valid[d]), 0);
      chk($sformatf("midrst dut%0d ch", d), int'(o_ch[d]), 0);
      chk($sformatf("midrst dut%0d data", d), int'(o_data[d]), 0);
      chk($sformatf("midrst dut%0d ovr", d), int'(o_ovr[d]), 0);
    end
    for (int k = 1; k <= 8; k++) begin
      strobe(2, k); idle(19);
    end
    chk("midrst s3 count", xlog[3].size(), 1);
    if (xlog[3].size() > 0) begin
      chk("midrst s3 ch", xlog[3][0].ch, 2);
      chk("midrst s3 mean 36>>>3", xlog[3][0].data, 4);
    end

    // Randomized traffic, model-checked every cycle
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      for (int n = 0; n < 16; n++) valid[n] = ($urandom_range(0, 11) == 0);
      for (int w = 0; w < 8; w++) data[32*w +: 32] = $urandom();
      ready = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 31) == 0);
      rst   = ($urandom_range(0, 599) == 0);
      cyc();
    end
    valid = '0; ready = 1'b1; clr = 1'b0; rst = 1'b0;
    idle(40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mean_scheduler.md
# mean_scheduler

Time-multiplexes one shared running-mean datapath across 16 acquisition channels. Each channel offers one signed 16-bit sample per valid pulse. A round-robin arbiter feeds the samples into per-channel accumulators and emits one channel-tagged average every 2^SHIFT samples of that channel. It sits between the 16-channel front-end sample registers and the downstream packer, replacing one averager per channel.

## Interface
- SHIFT, default 3 — averaging depth exponent, legal 0..6; AMOUNT = 2^SHIFT samples per average.
- CLK  in  1  — sole clock, all logic on rising edge.
- RESET  in  1  — synchronous, active-high reset.
- CH_VALID  in  16  — per-channel one-cycle sample strobe.
- CH_DATA  in  256  — channel n sample at bits [16n+15:16n], signed two's complement.
- OUT_READY  in  1  — downstream accepts result.
- CLR_OVR  in  1  — one-cycle pulse that clears all OVERRUN bits.
- OUT_VALID  out  1  — result held in output register.
- OUT_CH  out  4  — channel index of result.
- OUT_DATA  out  16  — signed mean.
- OVERRUN  out  16  — sticky per-channel sample-lost flags.

## Operation
- **Capture stage:** 16 hold registers and 16 pending bits.
  - CH_VALID[n]=1 loads hold[n] from the channel n slice of CH_DATA and sets pending[n].
  - If pending[n] is already set and channel n is not granted in the same cycle, the new sample overwrites hold[n] and OVERRUN[n] is set.
  - Valid and grant on the same channel in the same cycle: the old sample is consumed, the new one is captured, pending stays 1, no overrun.
- **Arbiter:** 16-way round-robin over pending.
  - Search starts at last_grant+1 mod 16. last_grant resets to 15, so channel 0 has first priority.
  - At most one grant per cycle.
  - A grant is issued only when the output slot is free or freeing: !OUT_VALID || OUT_READY.
- **Accumulate stage:** per channel, a signed (16+SHIFT)-bit acc and a SHIFT-bit cnt.
  - On grant of channel g:
    - If cnt[g] != AMOUNT-1: acc[g] += sext(hold[g]) and cnt[g] += 1.
    - Else: load OUT_DATA = (acc[g] + hold[g]) >>> SHIFT (arithmetic shift, floor toward −∞), OUT_CH = g, OUT_VALID = 1; then clear acc[g] and cnt[g] to 0.
  - SHIFT=0: every granted sample is output unchanged.
  - No overflow is possible: the accumulator width covers AMOUNT full-scale samples.
- **Output handshake:**
  - OUT_VALID=1 with OUT_READY=1 at an edge is a transfer.
  - OUT_VALID stays high with stable OUT_CH/OUT_DATA until transferred.
  - A new result may load on the same edge as a transfer, giving back-to-back output with no bubble.
- **Backpressure:** while stalled (OUT_VALID=1, OUT_READY=0) no grants are issued. Pending samples wait; further arrivals cause overrun.
- **Overrun clearing:** CLR_OVR clears OVERRUN. If CLR_OVR and a new overrun happen on the same cycle for a channel, the set wins.
- **Reset:** applies mid-operation too; any partial averages are discarded.
  - Outputs: OUT_VALID=0, OUT_CH=0, OUT_DATA=0, OVERRUN=0.
  - Internal: pending=0, acc=0, cnt=0, last_grant=15.

## Timing
- **Latency:** CH_VALID at edge E0, uncontended; grant is decided in the cycle after E0; the result is registered at E1. For the AMOUNT-th sample, OUT_VALID is high after E1.
- **Throughput:** 1 sample/cycle aggregate. Each channel is guaranteed lossless at ≤1 sample per 16 cycles with OUT_READY held high.
- **Worst-case wait:** 16 cycles from pending to grant without backpressure.
- **Logic depth:** the arbiter priority logic is combinational from pending/last_grant. The accumulate add and output shift are in one register stage; there is no combinational path from inputs to outputs.

## Structure
- **Package mean_sched_pkg:**
  - NCH=16, DW=16, CHW=4.
  - Function acc_width(shift)=DW+shift.
  - Function for channel slice extraction from CH_DATA.
- **Sub-module rr_arbiter:**
  - Parameter N.
  - Inputs: req[N], enable, last_grant pointer.
  - Outputs: grant_valid, grant_idx.
  - Purely combinational; the pointer register lives in mean_scheduler.
- Accumulators and counters are register arrays in mean_scheduler (no RAM required for 16 entries).

## Test plan
- **Single channel, SHIFT=2:** ch3 receives 100, 200, −50, 7 at 20-cycle spacing with OUT_READY=1 → exactly one output: OUT_CH=3, OUT_DATA=64 (257>>>2), OUT_VALID one cycle, two edges after the fourth strobe.
- **Negative floor, SHIFT=1:** ch0 receives −3, −2 → OUT_DATA=−3 (−5>>>1), not −2.
- **All 16 channels strobe in one cycle, SHIFT=0:** outputs appear on 16 consecutive cycles in order 0..15. A second all-channel burst 16 cycles later is also ordered 0..15, and OVERRUN stays 0.
- **Backpressure:** OUT_READY=0 for 40 cycles while ch5 strobes every 8 cycles → OUT_VALID and OUT_DATA stay frozen and OVERRUN[5]=1. A CLR_OVR pulse clears it once traffic stops.
- **Same-cycle consume and arrive:** ch7 strobes on the cycle it is granted → no OVERRUN, and the second sample is accumulated next.
- **Reset mid-average:** with SHIFT=3, apply RESET after 5 samples on ch2 → all outputs reset. The following 8 samples produce a mean of only those 8.
